// File: rtl/adc_seq_pkg.sv
// Shared types and widths for the ADC command sequencer.
package adc_seq_pkg;

  localparam int CH_W   = 5;
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    WAIT_RSP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/adc_seq_watchdog.sv
// Response watchdog: counts clocks while enabled, returns to zero when cleared,
// and flags expiry during the TIMEOUT-th counted clock.
module adc_seq_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire
);

  logic [15:0] cnt;

  // Expiry is seen while the counter holds TIMEOUT-1, i.e. in the last allowed clock.
  assign expire = !clear && (cnt == 16'(TIMEOUT - 1));

  // Free-running counter while armed; the owner leaves the wait state on expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!expire) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/adc_cmd_sequencer.sv
// ADC command sequencer: scans NUM_CH channels starting at CH_FIRST, issuing one
// Avalon-ST command at a time and forwarding each conversion result as a sample.
// Optional response watchdog enabled by defining ADC_SEQ_TIMEOUT_EN.
module adc_cmd_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CH_FIRST = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              enable,
  output logic              adc_command_valid,
  output logic [CH_W-1:0]   adc_command_channel,
  output logic              adc_command_startofpacket,
  output logic              adc_command_endofpacket,
  input  logic              adc_command_ready,
  input  logic              adc_response_valid,
  input  logic [CH_W-1:0]   adc_response_channel,
  input  logic [DATA_W-1:0] adc_response_data,
  input  logic              adc_response_startofpacket,
  input  logic              adc_response_endofpacket,
  output logic              sample_valid,
  output logic [CH_W-1:0]   sample_channel,
  output logic [DATA_W-1:0] sample_data,
  output logic              frame_done,
  output logic              err_flag
);

  localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

  seq_state_t        state, state_nxt;
  logic [SLOT_W-1:0] slot, slot_nxt;
  logic [CH_W-1:0]   cmd_ch;
  logic              rsp_accept;
  logic              rsp_stray;
  logic              slot_done;
  logic              timeout_skip;
  logic              wd_expire;

  // Response framing bits carry nothing the sequencer needs.
  logic unused_rsp_framing;
  assign unused_rsp_framing = adc_response_startofpacket ^ adc_response_endofpacket;

`ifdef ADC_SEQ_TIMEOUT_EN
  adc_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk_clk),
    .rst    (reset_reset),
    .clear  (state != WAIT_RSP),
    .expire (wd_expire)
  );
`else
  localparam int unused_timeout = TIMEOUT;
  assign wd_expire = 1'b0;
`endif

  assign cmd_ch = CH_W'(CH_FIRST) + CH_W'(slot);

  // A response is only legal while waiting; the handshake cycle itself is still CMD.
  assign rsp_stray    = adc_response_valid && (state != WAIT_RSP);
  assign timeout_skip = (state == WAIT_RSP) && !adc_response_valid && wd_expire;

  // State and slot index registers.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state <= IDLE;
      slot  <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  // Next-state, slot advance and command outputs.
  always_comb begin
    state_nxt                 = state;
    slot_nxt                  = slot;
    adc_command_valid         = 1'b0;
    adc_command_channel       = '0;
    adc_command_startofpacket = 1'b0;
    adc_command_endofpacket   = 1'b0;
    rsp_accept                = 1'b0;
    slot_done                 = 1'b0;
    case (state)
      IDLE: begin
        slot_nxt = '0;
        if (enable) begin
          state_nxt = CMD;
        end
      end
      CMD: begin
        // Command stays asserted until accepted, regardless of enable.
        adc_command_valid         = 1'b1;
        adc_command_channel       = cmd_ch;
        adc_command_startofpacket = (slot == '0);
        adc_command_endofpacket   = (slot == LAST_SLOT);
        if (adc_command_ready) begin
          state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        rsp_accept = adc_response_valid;
        slot_done  = adc_response_valid || wd_expire;
        if (slot_done) begin
          if (enable) begin
            state_nxt = CMD;
            slot_nxt  = (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
          end else begin
            state_nxt = IDLE;
            slot_nxt  = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        slot_nxt  = '0;
      end
    endcase
  end

  // Sample output register, frame pulse and sticky error.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sample_valid   <= 1'b0;
      sample_channel <= '0;
      sample_data    <= '0;
      frame_done     <= 1'b0;
      err_flag       <= 1'b0;
    end else begin
      sample_valid <= rsp_accept;
      frame_done   <= slot_done && (slot == LAST_SLOT);
      if (rsp_accept) begin
        sample_channel <= adc_response_channel;
        sample_data    <= adc_response_data;
      end
      if (rsp_stray || timeout_skip ||
          (rsp_accept && (adc_response_channel != cmd_ch))) begin
        err_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_cmd_sequencer.sv
// Scoreboard bench for adc_cmd_sequencer (NUM_CH=2, CH_FIRST=1, TIMEOUT=10).
module tb_adc_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        ready;
  logic        rsp_valid;
  logic [4:0]  rsp_ch;
  logic [11:0] rsp_data;
  logic        rsp_sop;
  logic        rsp_eop;
  logic        adc_command_valid;
  logic [4:0]  adc_command_channel;
  logic        adc_command_startofpacket;
  logic        adc_command_endofpacket;
  logic        sample_valid;
  logic [4:0]  sample_channel;
  logic [11:0] sample_data;
  logic        frame_done;
  logic        err_flag;

  always #5 clk = ~clk;

  adc_cmd_sequencer #(
    .NUM_CH   (2),
    .CH_FIRST (1),
    .TIMEOUT  (10)
  ) dut (
    .clk_clk                    (clk),
    .reset_reset                (rst),
    .enable                     (enable),
    .adc_command_valid          (adc_command_valid),
    .adc_command_channel        (adc_command_channel),
    .adc_command_startofpacket  (adc_command_startofpacket),
    .adc_command_endofpacket    (adc_command_endofpacket),
    .adc_command_ready          (ready),
    .adc_response_valid         (rsp_valid),
    .adc_response_channel       (rsp_ch),
    .adc_response_data          (rsp_data),
    .adc_response_startofpacket (rsp_sop),
    .adc_response_endofpacket   (rsp_eop),
    .sample_valid               (sample_valid),
    .sample_channel             (sample_channel),
    .sample_data                (sample_data),
    .frame_done                 (frame_done),
    .err_flag                   (err_flag)
  );

  typedef struct {
    logic [4:0]  ch;
    logic [11:0] data;
    logic        fd;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          hs_cnt = 0;
  int          stray_req = 0;
  logic        model_on = 1'b0;
  logic        bad_en = 1'b0;
  logic [4:0]  bad_ch = 5'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ADC model: answers 3 clocks after each handshake, or injects a stray response on request.
  initial begin : adc_model
    int stray_seen;
    logic [4:0] cmd_ch;
    stray_seen = 0;
    rsp_valid = 1'b0; rsp_ch = 5'd0; rsp_data = 12'd0; rsp_sop = 1'b0; rsp_eop = 1'b0;
    forever begin
      @(negedge clk);
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        rsp_valid = 1'b1; rsp_ch = 5'd3; rsp_data = 12'hABC;
        @(posedge clk); #1;
        rsp_valid = 1'b0;
      end else if (model_on && adc_command_valid && ready) begin
        cmd_ch = adc_command_channel;
        repeat (3) @(posedge clk);
        #1;
        rsp_valid = 1'b1;
        rsp_ch    = bad_en ? bad_ch : cmd_ch;
        rsp_data  = (cmd_ch == 5'd1) ? 12'h123 : 12'h456;
        exp_q.push_back('{ch: rsp_ch, data: rsp_data, fd: (cmd_ch == 5'd2), cyc: cyc + 1});
        @(posedge clk); #1;
        rsp_valid = 1'b0;
      end
    end
  end

  // Handshake counter.
  initial begin : hs_counter
    forever begin
      @(negedge clk);
      if (adc_command_valid && ready) hs_cnt++;
    end
  end

  // Monitor: compares every presented sample against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          check("sample_unexpected", 32'(exp_q.size() > 0), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sample_channel", sample_channel, e.ch);
          check("sample_data", sample_data, e.data);
          check("sample_frame_done", frame_done, e.fd);
          check("sample_latency_cyc", cyc, e.cyc);
        end
      end else if (frame_done) begin
        check("lone_frame_done", frame_done, 1'b0);
      end
    end
  end

  initial begin : global_limit
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!adc_command_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_seen"}, adc_command_valid, 1'b1);
  endtask

  // Waits for a handshake, checks the command fields, returns just after the handshake edge.
  task automatic wait_hs(input logic [4:0] ch, input logic sop, input logic eop, input string tag);
    int n = 0;
    @(negedge clk);
    while (!(adc_command_valid && ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_hs_seen"}, adc_command_valid && ready, 1'b1);
    check({tag, "_cmd"}, {adc_command_channel, adc_command_startofpacket, adc_command_endofpacket},
          {ch, sop, eop});
    @(posedge clk); #1;
  endtask

  initial begin : stimulus
    int h0;
    int i;
    rst = 1'b1; enable = 1'b0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {adc_command_valid, adc_command_startofpacket, adc_command_endofpacket, adc_command_channel,
           sample_valid, sample_channel, sample_data, frame_done, err_flag}, 32'd0);
    rst = 1'b0;

    // Continuous scan: ch1(sop)/ch2(eop) alternate.
    model_on = 1'b1; ready = 1'b1; enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_hs((k % 2) ? 5'd2 : 5'd1, (k % 2) == 0, (k % 2) == 1, "t1");
    end
    enable = 1'b0;
    wait_clks(6);
    check("t1_idle", adc_command_valid, 1'b0);
    check("t1_err", err_flag, 1'b0);

    // Backpressure: command held stable for 5 clocks, single handshake.
    ready = 1'b0; enable = 1'b1;
    h0 = hs_cnt;
    wait_valid("t2");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("t2_hold", {adc_command_valid, adc_command_channel, adc_command_startofpacket,
                        adc_command_endofpacket}, {1'b1, 5'd1, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    ready = 1'b1;
    wait_hs(5'd1, 1'b1, 1'b0, "t2");
    ready = 1'b0;
    wait_clks(8);
    check("t2_one_hs", hs_cnt - h0, 32'd1);
    check("t2_next_pending", {adc_command_valid, adc_command_channel}, {1'b1, 5'd2});
    enable = 1'b0; ready = 1'b1;
    wait_hs(5'd2, 1'b0, 1'b1, "t2b");
    wait_clks(6);
    check("t2_idle", adc_command_valid, 1'b0);

    // Enable dropped during CMD: command completes, then restart from ch1.
    ready = 1'b0; enable = 1'b1;
    wait_valid("t3");
    @(posedge clk); #1;
    enable = 1'b0;
    @(negedge clk);
    check("t3_valid_held", {adc_command_valid, adc_command_channel}, {1'b1, 5'd1});
    @(posedge clk); #1;
    ready = 1'b1;
    wait_hs(5'd1, 1'b1, 1'b0, "t3");
    ready = 1'b0;
    wait_clks(6);
    check("t3_idle", adc_command_valid, 1'b0);
    ready = 1'b1; enable = 1'b1;
    wait_hs(5'd1, 1'b1, 1'b0, "t3_restart");
    enable = 1'b0;
    wait_clks(6);

    // Wrong response channel: sample still forwarded, sticky error.
    check("t4_err_before", err_flag, 1'b0);
    bad_en = 1'b1; bad_ch = 5'd7; enable = 1'b1; ready = 1'b1;
    wait_hs(5'd1, 1'b1, 1'b0, "t4");
    enable = 1'b0;
    wait_clks(5);
    check("t4_err_set", err_flag, 1'b1);
    bad_en = 1'b0;
    wait_clks(5);
    check("t4_err_sticky", err_flag, 1'b1);

    // Reset during WAIT_RSP clears every output at once; stray response afterwards is an error.
    model_on = 1'b0; enable = 1'b1; ready = 1'b1;
    wait_hs(5'd1, 1'b1, 1'b0, "t6");
    enable = 1'b0;
    wait_clks(2);
    check("t6_pre_reset_ch", sample_channel, 5'd7);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("t6_reset_outputs",
          {adc_command_valid, adc_command_startofpacket, adc_command_endofpacket, adc_command_channel,
           sample_valid, sample_channel, sample_data, frame_done, err_flag}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_clks(2);
    check("t6_err_after_release", err_flag, 1'b0);
    stray_req++;
    wait_clks(3);
    check("t6_stray_err", err_flag, 1'b1);

    // No response at all.
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    check("t5_err_clear", err_flag, 1'b0);
    enable = 1'b1; ready = 1'b1;
    wait_hs(5'd1, 1'b1, 1'b0, "t5");
`ifdef ADC_SEQ_TIMEOUT_EN
    i = 1;
    @(negedge clk);
    while (!err_flag && i < 30) begin
      @(negedge clk);
      i++;
    end
    check("t5_timeout_wait_clocks", i - 1, 32'd10);
    check("t5_next_cmd", {adc_command_valid, adc_command_channel, adc_command_endofpacket},
          {1'b1, 5'd2, 1'b1});
    wait_clks(3);
`else
    i = 0;
    h0 = hs_cnt;
    wait_clks(1000);
    check("t5_still_waiting_hs", hs_cnt - h0, 32'd0);
    check("t5_still_waiting_err", err_flag, 1'b0);
    check("t5_still_waiting_valid", adc_command_valid, 1'b0);
`endif
    enable = 1'b0;
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(5);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
